// File: rtl/rr_req_client_if.sv
// Signal bundle between one round-robin requester client, its local beat source,
// the arbiter's request/grant pair and the shared output bus.
interface rr_req_client_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          req;
  logic          gnt;
  logic          bus_valid;
  logic [DW-1:0] bus_data;
  logic          bus_last;
  logic          lost_gnt;
  logic          timeout;

  modport slave (
    input  in_valid, in_data, in_last, gnt,
    output in_ready, req, bus_valid, bus_data, bus_last, lost_gnt, timeout
  );

  modport master (
    output in_valid, in_data, in_last, gnt,
    input  in_ready, req, bus_valid, bus_data, bus_last, lost_gnt, timeout
  );
endinterface

// File: rtl/rr_req_client.sv
// Requester-side agent for a 4-way round-robin arbiter: FIFO-buffers local beats,
// requests, streams a bounded burst per grant. Optional REQ wait limit: RR_REQ_TIMEOUT_EN.
module rr_req_client #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rr_req_client_if.slave  io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BURST_MAX < 1 || BURST_MAX > 15 || TIMEOUT < 1) begin : g_badParams
    $error("rr_req_client: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    GAP
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [DW-1:0] r_memData [DEPTH];
  logic          r_memLast [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [BW-1:0] r_beatCnt;

  logic          r_busValid;
  logic [DW-1:0] r_busData;
  logic          r_busLast;
  logic          r_lostGnt;

  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_clearBeat;
  logic          w_lostGnt;

  // Full/empty come from the registered count, so a pop at full frees the slot only next cycle.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_push  = io.in_valid && !w_full;

  assign io.in_ready  = !w_full;
  assign io.req       = (r_state == REQ) || (r_state == XFER);
  assign io.bus_valid = r_busValid;
  assign io.bus_data  = r_busData;
  assign io.bus_last  = r_busLast;
  assign io.lost_gnt  = r_lostGnt;

`ifdef RR_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] r_waitCnt;
  logic          r_timeout;
  logic          w_waitExpired;
  logic          w_timeoutHit;

  assign w_waitExpired = (r_waitCnt == WW'(TIMEOUT - 1));
  assign io.timeout    = r_timeout;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_waitCnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeoutHit;
      if (r_state == REQ && w_nextState == REQ)
        r_waitCnt <= r_waitCnt + WW'(1);
      else
        r_waitCnt <= '0;
    end
  end
`else
  assign io.timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Next-state decode; a burst closes on the beat carrying last or the BURST_MAX-th beat.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_clearBeat = 1'b0;
    w_lostGnt   = 1'b0;
`ifdef RR_REQ_TIMEOUT_EN
    w_timeoutHit = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_empty)
          w_nextState = REQ;
      end
      REQ: begin
        if (io.gnt) begin
          w_nextState = XFER;
          w_clearBeat = 1'b1;
        end
`ifdef RR_REQ_TIMEOUT_EN
        else if (w_waitExpired) begin
          w_nextState  = GAP;
          w_timeoutHit = 1'b1;
        end
`endif
      end
      XFER: begin
        if (!io.gnt) begin
          w_nextState = GAP;
          w_lostGnt   = 1'b1;
        end else if (!w_empty) begin
          w_pop = 1'b1;
          if (r_memLast[r_rdPtr] || r_beatCnt == BW'(BURST_MAX - 1))
            w_nextState = GAP;
        end
      end
      GAP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_memData[r_wrPtr] <= io.in_data;
      r_memLast[r_wrPtr] <= io.in_last;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_beatCnt <= '0;
    else if (w_clearBeat)
      r_beatCnt <= '0;
    else if (w_pop)
      r_beatCnt <= r_beatCnt + BW'(1);
  end

  // Bus data holds its previous value between beats.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busValid <= 1'b0;
      r_busData  <= '0;
      r_busLast  <= 1'b0;
      r_lostGnt  <= 1'b0;
    end else begin
      r_busValid <= w_pop;
      r_lostGnt  <= w_lostGnt;
      if (w_pop) begin
        r_busData <= r_memData[r_rdPtr];
        r_busLast <= r_memLast[r_rdPtr];
      end
    end
  end
endmodule

// File: tb/tb_rr_req_client.sv
// Scoreboard bench for rr_req_client: accepted beats are queued and matched
// against the shared bus; handshake timing is checked at fixed cycle offsets.
module tb_rr_req_client;
  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk;
  logic rstN;

  rr_req_client_if #(.DW(8)) io ();

  rr_req_client #(
    .DW(8),
    .DEPTH(4),
    .BURST_MAX(4),
    .TIMEOUT(15)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .io(io)
  );

  int    checkCount = 0;
  int    errorCount = 0;
  int    beatsSeen  = 0;
  int    runLen     = 0;
  int    runQ[$];
  beat_t expQ[$];
  bit    autoGnt    = 0;
  bit    manualGnt  = 0;
  logic  sampledReq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter stand-in: registered grant that follows req one cycle later, or a manual level.
  always @(posedge clk) begin
    sampledReq = io.req;
    #2;
    io.gnt = autoGnt ? sampledReq : manualGnt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bus monitor: every beat must match the oldest accepted push; burst run lengths are logged.
  always @(negedge clk) begin
    beat_t exp;
    if (io.bus_valid === 1'b1) begin
      beatsSeen++;
      runLen++;
      if (expQ.size() == 0)
        checkOutput("bus_unexpected", expQ.size(), 1);
      else begin
        exp = expQ.pop_front();
        checkOutput("bus_data", io.bus_data, exp.data);
        checkOutput("bus_last", io.bus_last, exp.last);
      end
    end else if (runLen > 0) begin
      runQ.push_back(runLen);
      runLen = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic last);
    bit accepted;
    accepted = 1'b0;
    io.in_valid = 1'b1;
    io.in_data  = data;
    io.in_last  = last;
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(posedge clk);
      accepted = (io.in_ready === 1'b1);
      #1;
    end
    if (accepted)
      expQ.push_back(beat_t'{data: data, last: last});
    else
      checkOutput("push_accept", accepted, 1);
    io.in_valid = 1'b0;
  endtask

  task automatic waitBeats(input int target, input int budget);
    for (int i = 0; i < budget && beatsSeen < target; i++) tick();
    checkOutput("beat_count", beatsSeen, target);
  endtask

  task automatic waitReq(input int budget);
    for (int i = 0; i < budget && io.req !== 1'b1; i++) tick();
    if (io.req !== 1'b1) checkOutput("req_wait", io.req, 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=stuck expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    io.in_valid = 1'b0;
    io.in_data  = '0;
    io.in_last  = 1'b0;
    rstN = 1'b0;
    tickN(2);
    checkOutput("rst_req", io.req, 0);
    checkOutput("rst_bus_valid", io.bus_valid, 0);
    checkOutput("rst_bus_data", io.bus_data, 0);
    checkOutput("rst_bus_last", io.bus_last, 0);
    checkOutput("rst_lost_gnt", io.lost_gnt, 0);
    checkOutput("rst_timeout", io.timeout, 0);
    checkOutput("rst_in_ready", io.in_ready, 1);
    rstN = 1'b1;
    tick();

    $display("[TB] three-beat packet with manual grant");
    applyStimulus(8'h11, 1'b0);
    checkOutput("t1_req_t1", io.req, 0);
    tick();
    checkOutput("t1_req_t2", io.req, 1);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b1);
    manualGnt = 1'b1;
    tick();
    checkOutput("t1_valid_g1", io.bus_valid, 0);
    tick();
    checkOutput("t1_valid_g2", io.bus_valid, 1);
    tickN(2);
    checkOutput("t1_gap_req", io.req, 0);
    checkOutput("t1_gap_last", io.bus_last, 1);
    manualGnt = 1'b0;
    tick();
    checkOutput("t1_idle_req", io.req, 0);
    waitBeats(3, 20);

    $display("[TB] six-beat packet split by BURST_MAX");
    tickN(2);
    runQ.delete();
    base = beatsSeen;
    for (int i = 0; i < 4; i++) applyStimulus(8'h20 + 8'(i), 1'b0);
    checkOutput("t2_full_ready", io.in_ready, 0);
    autoGnt = 1'b1;
    applyStimulus(8'h24, 1'b0);
    applyStimulus(8'h25, 1'b1);
    waitBeats(base + 6, 60);
    tickN(3);
    autoGnt = 1'b0;
    checkOutput("t2_runs", runQ.size(), 2);
    if (runQ.size() == 2) begin
      checkOutput("t2_run0", runQ[0], 4);
      checkOutput("t2_run1", runQ[1], 2);
    end

    $display("[TB] grant withdrawn mid-burst");
    tickN(2);
    base = beatsSeen;
    for (int i = 0; i < 4; i++) applyStimulus(8'h40 + 8'(i), i == 3);
    waitReq(10);
    manualGnt = 1'b1;
    tickN(3);
    manualGnt = 1'b0;
    tick();
    checkOutput("t3_lost_pulse", io.lost_gnt, 1);
    checkOutput("t3_lost_valid", io.bus_valid, 0);
    checkOutput("t3_lost_req", io.req, 0);
    checkOutput("t3_beats_before", beatsSeen - base, 2);
    tick();
    checkOutput("t3_lost_clear", io.lost_gnt, 0);
    autoGnt = 1'b1;
    waitBeats(base + 4, 40);
    tickN(3);
    autoGnt = 1'b0;

    $display("[TB] streaming through full FIFO with pointer wrap");
    tickN(2);
    base = beatsSeen;
    for (int i = 0; i < 4; i++) applyStimulus(8'h80 + 8'(i), 1'b0);
    checkOutput("t4_full_ready", io.in_ready, 0);
    autoGnt = 1'b1;
    for (int i = 4; i < 12; i++) applyStimulus(8'h80 + 8'(i), i == 11);
    waitBeats(base + 12, 80);
    tickN(3);
    autoGnt = 1'b0;
    checkOutput("t4_sb_empty", expQ.size(), 0);

    $display("[TB] REQ wait without grant");
    tickN(2);
    base = beatsSeen;
    applyStimulus(8'h5A, 1'b1);
    waitReq(10);
`ifdef RR_REQ_TIMEOUT_EN
    for (int i = 1; i < 15; i++) begin
      tick();
      checkOutput("t5_no_timeout_yet", io.timeout, 0);
    end
    tick();
    checkOutput("t5_timeout_pulse", io.timeout, 1);
    checkOutput("t5_timeout_req", io.req, 0);
    tick();
    checkOutput("t5_timeout_clear", io.timeout, 0);
    tick();
    checkOutput("t5_rereq", io.req, 1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOutput("t5_timeout_tied", io.timeout, 0);
      checkOutput("t5_req_held", io.req, 1);
    end
`endif
    autoGnt = 1'b1;
    waitBeats(base + 1, 20);
    tickN(3);
    autoGnt = 1'b0;

    $display("[TB] reset in the middle of a burst");
    tickN(2);
    for (int i = 0; i < 4; i++) applyStimulus(8'h60 + 8'(i), i == 3);
    base = beatsSeen;
    autoGnt = 1'b1;
    waitBeats(base + 1, 20);
    rstN = 1'b0;
    tick();
    expQ.delete();
    autoGnt = 1'b0;
    rstN = 1'b1;
    checkOutput("t6_req", io.req, 0);
    checkOutput("t6_bus_valid", io.bus_valid, 0);
    checkOutput("t6_bus_data", io.bus_data, 0);
    checkOutput("t6_bus_last", io.bus_last, 0);
    checkOutput("t6_lost_gnt", io.lost_gnt, 0);
    checkOutput("t6_timeout", io.timeout, 0);
    checkOutput("t6_in_ready", io.in_ready, 1);
    base = beatsSeen;
    tickN(6);
    checkOutput("t6_no_beats", beatsSeen, base);
    checkOutput("t6_idle_req", io.req, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
